// File: rtl/votador_bist_pkg.sv
// Shared definitions for the majority-voter self-test controller:
// FSM state type and default parameter values.
package votador_bist_pkg;

    localparam int N_DEFAULT      = 3;
    localparam int SETTLE_DEFAULT = 1;
    localparam int ERRW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/votador_ref.sv
// Combinational popcount-majority reference: 1 when at least (N+1)/2 inputs are set.
module votador_ref import votador_bist_pkg::*; #(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] vec_i,
    output logic         maj_o
);

    localparam int unsigned HALF = (N + 1) / 2;

    int unsigned ones;

    always_comb begin
        ones = 0;
        for (int unsigned i = 0; i < N; i++) begin
            ones = ones + 32'(vec_i[i]);
        end
        maj_o = (ones >= HALF);
    end

endmodule

// File: rtl/votador_bist.sv
// Self-test controller: sweeps every N-bit vector through the voter under test and
// counts disagreements with the built-in majority reference.
module votador_bist import votador_bist_pkg::*; #(
    parameter int N      = N_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT,
    parameter int ERRW   = ERRW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            v_dut,
    output logic [N-1:0]    stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_count,
    output logic [N-1:0]    first_err
);

    localparam int              SW          = $clog2(SETTLE) + 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

    state_t          state_q;
    logic [SW-1:0]   settle_q;
    logic [N-1:0]    stim_q;
    logic [N-1:0]    first_q;
    logic [ERRW-1:0] err_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;

    logic            ref_v;
    logic            mismatch_d;
    logic [ERRW-1:0] err_d;

    votador_ref #(.N(N)) u_ref (
        .vec_i (stim_q),
        .maj_o (ref_v)
    );

    always_comb begin
        mismatch_d = (v_dut != ref_v);
        err_d      = err_q;
        if (mismatch_d && (err_q != '1)) begin
            err_d = err_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            stim_q   <= '0;
            first_q  <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_APPLY;
                        settle_q <= '0;
                        stim_q   <= '0;
                        first_q  <= '0;
                        err_q    <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_CHECK: begin
                    err_q <= err_d;
                    // err_q is still zero only until the first disagreement is seen
                    if (mismatch_d && (err_q == '0)) begin
                        first_q <= stim_q;
                    end
                    if (stim_q == '1) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        stim_q  <= stim_q + N'(1);
                        state_q <= ST_APPLY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign first_err = first_q;

endmodule
